// File: rtl/stage_wb_if.sv
// Writeback-stage bus between the MEM stage / data memory (master) and stage_wb (slave).
// Carries the captured instruction fields, the memory read return and the decode-stage write port.
interface stage_wb_if;
   logic        Valid_in_WB;
   logic        RegWrite_in_WB;
   logic        MemtoReg_in_WB;
   logic [1:0]  size_in_WB;
   logic [31:0] ALUResult_in_WB;
   logic [4:0]  WriteRegister_in_WB;
   logic [31:0] ReadData_in_WB;
   logic        MemReady_in;
   logic        RegWrite_out;
   logic [4:0]  WriteRegister_out;
   logic [31:0] WriteData_out;
   logic        Stall_out;
   logic [31:0] RetireCount_out;

   modport master (
      output Valid_in_WB, RegWrite_in_WB, MemtoReg_in_WB, size_in_WB,
             ALUResult_in_WB, WriteRegister_in_WB, ReadData_in_WB, MemReady_in,
      input  RegWrite_out, WriteRegister_out, WriteData_out, Stall_out, RetireCount_out
   );

   modport slave (
      input  Valid_in_WB, RegWrite_in_WB, MemtoReg_in_WB, size_in_WB,
             ALUResult_in_WB, WriteRegister_in_WB, ReadData_in_WB, MemReady_in,
      output RegWrite_out, WriteRegister_out, WriteData_out, Stall_out, RetireCount_out
   );
endinterface

// File: rtl/stage_wb.sv
// Writeback stage: captures MEM results, waits for load data, aligns/sign-extends and writes the register file.
// Optional retire counter enabled by defining STAGE_WB_RETIRE_COUNT_EN.
module stage_wb (
   input logic       Clk_in,
   input logic       Reset,
   stage_wb_if.slave wb
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      WRITE    = 2'd2
   } state_t;

   state_t      state_r;
   logic        reg_write_r;
   logic        mem_to_reg_r;
   logic [1:0]  size_r;
   logic [31:0] alu_result_r;
   logic [4:0]  write_register_r;
   logic [31:0] load_data_r;
   logic [31:0] aligned_load_s;

   // Big-endian lane selection: the lowest address holds the most significant bits.
   function automatic logic [31:0] align_load(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  addr);
      logic [31:0] result;
      result = word;
      case (size)
         2'b01: begin
            if (addr[1] == 1'b0) result = {{16{word[31]}}, word[31:16]};
            else                 result = {{16{word[15]}}, word[15:0]};
         end
         2'b10: begin
            case (addr)
               2'b00:   result = {{24{word[31]}}, word[31:24]};
               2'b01:   result = {{24{word[23]}}, word[23:16]};
               2'b10:   result = {{24{word[15]}}, word[15:8]};
               2'b11:   result = {{24{word[7]}},  word[7:0]};
               default: result = word;
            endcase
         end
         default: result = word;
      endcase
      return result;
   endfunction

   // Stage FSM together with the stage register and load buffer.
   always_ff @(posedge Clk_in) begin
      if (Reset) begin
         state_r          <= IDLE;
         reg_write_r      <= 1'b0;
         mem_to_reg_r     <= 1'b0;
         size_r           <= 2'b00;
         alu_result_r     <= 32'd0;
         write_register_r <= 5'd0;
         load_data_r      <= 32'd0;
      end else begin
         case (state_r)
            IDLE, WRITE: begin
               if (wb.Valid_in_WB) begin
                  reg_write_r      <= wb.RegWrite_in_WB;
                  mem_to_reg_r     <= wb.MemtoReg_in_WB;
                  size_r           <= wb.size_in_WB;
                  alu_result_r     <= wb.ALUResult_in_WB;
                  write_register_r <= wb.WriteRegister_in_WB;
                  state_r          <= wb.MemtoReg_in_WB ? WAIT_MEM : WRITE;
               end else begin
                  state_r <= IDLE;
               end
            end
            WAIT_MEM: begin
               if (wb.MemReady_in) begin
                  load_data_r <= wb.ReadData_in_WB;
                  state_r     <= WRITE;
               end else begin
                  state_r <= WAIT_MEM;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign aligned_load_s       = align_load(load_data_r, size_r, alu_result_r[1:0]);
   assign wb.Stall_out         = (state_r == WAIT_MEM);
   assign wb.RegWrite_out      = (state_r == WRITE) && reg_write_r && (write_register_r != 5'd0);
   assign wb.WriteRegister_out = write_register_r;
   assign wb.WriteData_out     = mem_to_reg_r ? aligned_load_s : alu_result_r;

`ifdef STAGE_WB_RETIRE_COUNT_EN
   logic [31:0] retire_count_r;

   // Every cycle spent in WRITE retires exactly one instruction, including writes to r0.
   always_ff @(posedge Clk_in) begin
      if (Reset) begin
         retire_count_r <= 32'd0;
      end else if (state_r == WRITE) begin
         retire_count_r <= retire_count_r + 32'd1;
      end else begin
         retire_count_r <= retire_count_r;
      end
   end

   assign wb.RetireCount_out = retire_count_r;
`else
   assign wb.RetireCount_out = 32'd0;
`endif

endmodule

// File: tb/tb_stage_wb.sv
// Self-checking bench for stage_wb: expected writes are queued at capture and popped in the WRITE cycle.
module tb_stage_wb;

   typedef struct {
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

`ifdef STAGE_WB_RETIRE_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        Clk_in;
   logic        Reset;
   stage_wb_if  wb_if ();

   exp_t        sb[$];
   int          tests_run;
   int          tests_failed;
   logic [31:0] exp_count;

   stage_wb dut (
      .Clk_in (Clk_in),
      .Reset  (Reset),
      .wb     (wb_if.slave)
   );

   initial Clk_in = 1'b0;
   always #5 Clk_in = ~Clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge Clk_in);
      @(negedge Clk_in);
   endtask

   function automatic logic [31:0] exp_cnt_now();
      return CNT_EN ? exp_count : 32'd0;
   endfunction

   task automatic drive_op(input logic rw, input logic m2r, input logic [1:0] sz,
                           input logic [31:0] alu, input logic [4:0] rd);
      wb_if.Valid_in_WB         = 1'b1;
      wb_if.RegWrite_in_WB      = rw;
      wb_if.MemtoReg_in_WB      = m2r;
      wb_if.size_in_WB          = sz;
      wb_if.ALUResult_in_WB     = alu;
      wb_if.WriteRegister_in_WB = rd;
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      exp_count = 32'd0;
      tests_run++; if (wb_if.RegWrite_out !== 1'b0) begin tests_failed++; $display("FAIL reset_regwrite: got %b want 0", wb_if.RegWrite_out); end
      tests_run++; if (wb_if.WriteRegister_out !== 5'd0) begin tests_failed++; $display("FAIL reset_wreg: got %0d want 0", wb_if.WriteRegister_out); end
      tests_run++; if (wb_if.WriteData_out !== 32'd0) begin tests_failed++; $display("FAIL reset_wdata: got %h want 0", wb_if.WriteData_out); end
      tests_run++; if (wb_if.Stall_out !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", wb_if.Stall_out); end
      tests_run++; if (wb_if.RetireCount_out !== 32'd0) begin tests_failed++; $display("FAIL reset_count: got %h want 0", wb_if.RetireCount_out); end
   endtask

   task automatic test_alu;
      exp_t e;
      drive_op(1'b1, 1'b0, 2'b00, 32'h0000_1234, 5'd8);
      sb.push_back('{rw: 1'b1, rd: 5'd8, data: 32'h0000_1234});
      tick();
      wb_if.Valid_in_WB = 1'b0;
      e = sb.pop_front();
      exp_count = exp_count + 32'd1;
      tests_run++; if (wb_if.RegWrite_out !== e.rw) begin tests_failed++; $display("FAIL alu_regwrite: got %b want %b", wb_if.RegWrite_out, e.rw); end
      tests_run++; if (wb_if.WriteRegister_out !== e.rd) begin tests_failed++; $display("FAIL alu_wreg: got %0d want %0d", wb_if.WriteRegister_out, e.rd); end
      tests_run++; if (wb_if.WriteData_out !== e.data) begin tests_failed++; $display("FAIL alu_wdata: got %h want %h", wb_if.WriteData_out, e.data); end
      tests_run++; if (wb_if.Stall_out !== 1'b0) begin tests_failed++; $display("FAIL alu_stall: got %b want 0", wb_if.Stall_out); end
      tick();
      tests_run++; if (wb_if.RegWrite_out !== 1'b0) begin tests_failed++; $display("FAIL alu_idle_regwrite: got %b want 0", wb_if.RegWrite_out); end
      tests_run++; if (wb_if.RetireCount_out !== exp_cnt_now()) begin tests_failed++; $display("FAIL alu_count: got %h want %h", wb_if.RetireCount_out, exp_cnt_now()); end
   endtask

   task automatic test_byte_load;
      exp_t e;
      wb_if.MemReady_in    = 1'b0;
      wb_if.ReadData_in_WB = 32'h0000_0000;
      drive_op(1'b1, 1'b1, 2'b10, 32'h1000_0003, 5'd9);
      sb.push_back('{rw: 1'b1, rd: 5'd9, data: 32'hFFFF_FF80});
      tick();
      for (int i = 0; i < 3; i++) begin
         // unrelated traffic on the bus must be ignored while waiting
         drive_op(1'b1, 1'b0, 2'b00, 32'hDEAD_0000 + 32'(i), 5'd31);
         wb_if.MemReady_in    = (i == 2);
         wb_if.ReadData_in_WB = (i == 2) ? 32'h1122_3380 : 32'hFFFF_FFFF;
         tests_run++; if (wb_if.Stall_out !== 1'b1) begin tests_failed++; $display("FAIL byte_stall[%0d]: got %b want 1", i, wb_if.Stall_out); end
         tests_run++; if (wb_if.RegWrite_out !== 1'b0) begin tests_failed++; $display("FAIL byte_wait_regwrite[%0d]: got %b want 0", i, wb_if.RegWrite_out); end
         tests_run++; if (wb_if.WriteRegister_out !== 5'd9) begin tests_failed++; $display("FAIL byte_wait_wreg[%0d]: got %0d want 9", i, wb_if.WriteRegister_out); end
         tick();
      end
      wb_if.Valid_in_WB = 1'b0;
      wb_if.MemReady_in = 1'b0;
      e = sb.pop_front();
      exp_count = exp_count + 32'd1;
      tests_run++; if (wb_if.RegWrite_out !== e.rw) begin tests_failed++; $display("FAIL byte_regwrite: got %b want %b", wb_if.RegWrite_out, e.rw); end
      tests_run++; if (wb_if.WriteRegister_out !== e.rd) begin tests_failed++; $display("FAIL byte_wreg: got %0d want %0d", wb_if.WriteRegister_out, e.rd); end
      tests_run++; if (wb_if.WriteData_out !== e.data) begin tests_failed++; $display("FAIL byte_wdata: got %h want %h", wb_if.WriteData_out, e.data); end
      tests_run++; if (wb_if.Stall_out !== 1'b0) begin tests_failed++; $display("FAIL byte_write_stall: got %b want 0", wb_if.Stall_out); end
      tick();
   endtask

   task automatic test_load_align;
      logic [1:0]  sz_t  [7] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
      logic [31:0] adr_t [7] = '{32'h2000_0000, 32'h2000_0002, 32'h2000_0000, 32'h2000_0001,
                                 32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
      logic [31:0] dat_t [7] = '{32'h7ABC_0000, 32'h1234_8001, 32'h8011_2233, 32'h0012_0000,
                                 32'h0000_7F00, 32'hCAFE_F00D, 32'h8000_0001};
      logic [31:0] exp_t_ [7] = '{32'h0000_7ABC, 32'hFFFF_8001, 32'hFFFF_FF80, 32'h0000_0012,
                                  32'h0000_007F, 32'hCAFE_F00D, 32'h8000_0001};
      exp_t e;
      for (int i = 0; i < 7; i++) begin
         drive_op(1'b1, 1'b1, sz_t[i], adr_t[i], 5'(i + 10));
         wb_if.MemReady_in    = 1'b1;
         wb_if.ReadData_in_WB = ~dat_t[i];
         sb.push_back('{rw: 1'b1, rd: 5'(i + 10), data: exp_t_[i]});
         tick();
         wb_if.Valid_in_WB    = 1'b0;
         wb_if.ReadData_in_WB = dat_t[i];
         tests_run++; if (wb_if.Stall_out !== 1'b1) begin tests_failed++; $display("FAIL align_stall[%0d]: got %b want 1", i, wb_if.Stall_out); end
         tick();
         wb_if.MemReady_in = 1'b0;
         e = sb.pop_front();
         exp_count = exp_count + 32'd1;
         tests_run++; if (wb_if.WriteData_out !== e.data) begin tests_failed++; $display("FAIL align_wdata[%0d]: got %h want %h", i, wb_if.WriteData_out, e.data); end
         tests_run++; if (wb_if.RegWrite_out !== e.rw) begin tests_failed++; $display("FAIL align_regwrite[%0d]: got %b want %b", i, wb_if.RegWrite_out, e.rw); end
         tests_run++; if (wb_if.WriteRegister_out !== e.rd) begin tests_failed++; $display("FAIL align_wreg[%0d]: got %0d want %0d", i, wb_if.WriteRegister_out, e.rd); end
         tick();
      end
   endtask

   task automatic test_rd0;
      exp_t e;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      exp_count = 32'd0;
      drive_op(1'b1, 1'b0, 2'b00, 32'h0000_0055, 5'd0);
      sb.push_back('{rw: 1'b0, rd: 5'd0, data: 32'h0000_0055});
      tick();
      drive_op(1'b1, 1'b0, 2'b00, 32'h0000_0066, 5'd3);
      sb.push_back('{rw: 1'b1, rd: 5'd3, data: 32'h0000_0066});
      e = sb.pop_front();
      exp_count = exp_count + 32'd1;
      tests_run++; if (wb_if.RegWrite_out !== e.rw) begin tests_failed++; $display("FAIL rd0_regwrite: got %b want %b", wb_if.RegWrite_out, e.rw); end
      tests_run++; if (wb_if.WriteData_out !== e.data) begin tests_failed++; $display("FAIL rd0_wdata: got %h want %h", wb_if.WriteData_out, e.data); end
      tick();
      wb_if.Valid_in_WB = 1'b0;
      e = sb.pop_front();
      exp_count = exp_count + 32'd1;
      tests_run++; if (wb_if.RegWrite_out !== e.rw) begin tests_failed++; $display("FAIL rd3_regwrite: got %b want %b", wb_if.RegWrite_out, e.rw); end
      tests_run++; if (wb_if.WriteRegister_out !== e.rd) begin tests_failed++; $display("FAIL rd3_wreg: got %0d want %0d", wb_if.WriteRegister_out, e.rd); end
      tick();
      tests_run++; if (wb_if.RetireCount_out !== exp_cnt_now()) begin tests_failed++; $display("FAIL rd0_count: got %h want %h", wb_if.RetireCount_out, exp_cnt_now()); end
   endtask

   task automatic test_back_to_back;
      logic [4:0] rd_t [5] = '{5'd1, 5'd2, 5'd3, 5'd31, 5'd4};
      logic       rw_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] d;
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         d = $urandom;
         drive_op(rw_t[i], 1'b0, 2'b00, d, rd_t[i]);
         sb.push_back('{rw: rw_t[i] && (rd_t[i] != 5'd0), rd: rd_t[i], data: d});
         tick();
         e = sb.pop_front();
         exp_count = exp_count + 32'd1;
         tests_run++; if (wb_if.RegWrite_out !== e.rw) begin tests_failed++; $display("FAIL b2b_regwrite[%0d]: got %b want %b", i, wb_if.RegWrite_out, e.rw); end
         tests_run++; if (wb_if.WriteData_out !== e.data) begin tests_failed++; $display("FAIL b2b_wdata[%0d]: got %h want %h", i, wb_if.WriteData_out, e.data); end
         tests_run++; if (wb_if.Stall_out !== 1'b0) begin tests_failed++; $display("FAIL b2b_stall[%0d]: got %b want 0", i, wb_if.Stall_out); end
      end
      wb_if.Valid_in_WB = 1'b0;
      tick();
      tests_run++; if (wb_if.RegWrite_out !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle_regwrite: got %b want 0", wb_if.RegWrite_out); end
      tests_run++; if (wb_if.RetireCount_out !== exp_cnt_now()) begin tests_failed++; $display("FAIL b2b_count: got %h want %h", wb_if.RetireCount_out, exp_cnt_now()); end
   endtask

   task automatic test_reset_wait_mem;
      drive_op(1'b1, 1'b1, 2'b00, 32'h3000_0000, 5'd12);
      wb_if.MemReady_in = 1'b0;
      tick();
      wb_if.Valid_in_WB = 1'b0;
      tests_run++; if (wb_if.Stall_out !== 1'b1) begin tests_failed++; $display("FAIL rstwait_stall_pre: got %b want 1", wb_if.Stall_out); end
      wb_if.MemReady_in    = 1'b1;
      wb_if.ReadData_in_WB = 32'hA5A5_A5A5;
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      wb_if.MemReady_in = 1'b0;
      exp_count = 32'd0;
      tests_run++; if (wb_if.Stall_out !== 1'b0) begin tests_failed++; $display("FAIL rstwait_stall: got %b want 0", wb_if.Stall_out); end
      tests_run++; if (wb_if.RegWrite_out !== 1'b0) begin tests_failed++; $display("FAIL rstwait_regwrite: got %b want 0", wb_if.RegWrite_out); end
      tests_run++; if (wb_if.WriteData_out !== 32'd0) begin tests_failed++; $display("FAIL rstwait_wdata: got %h want 0", wb_if.WriteData_out); end
      tests_run++; if (wb_if.WriteRegister_out !== 5'd0) begin tests_failed++; $display("FAIL rstwait_wreg: got %0d want 0", wb_if.WriteRegister_out); end
      tests_run++; if (wb_if.RetireCount_out !== 32'd0) begin tests_failed++; $display("FAIL rstwait_count: got %h want 0", wb_if.RetireCount_out); end
      tick();
      tests_run++; if (wb_if.RegWrite_out !== 1'b0) begin tests_failed++; $display("FAIL rstwait_later_regwrite: got %b want 0", wb_if.RegWrite_out); end
   endtask

   task automatic test_wrap;
`ifdef STAGE_WB_RETIRE_COUNT_EN
      force dut.retire_count_r = 32'hFFFF_FFFF;
      release dut.retire_count_r;
      exp_count = 32'hFFFF_FFFF;
      tests_run++; if (wb_if.RetireCount_out !== exp_cnt_now()) begin tests_failed++; $display("FAIL wrap_preload: got %h want %h", wb_if.RetireCount_out, exp_cnt_now()); end
`endif
      drive_op(1'b1, 1'b0, 2'b00, 32'h0000_0042, 5'd7);
      tick();
      wb_if.Valid_in_WB = 1'b0;
      exp_count = exp_count + 32'd1;
      tick();
      tests_run++; if (wb_if.RetireCount_out !== exp_cnt_now()) begin tests_failed++; $display("FAIL wrap_count: got %h want %h", wb_if.RetireCount_out, exp_cnt_now()); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      exp_count    = 32'd0;
      Reset        = 1'b1;
      wb_if.Valid_in_WB         = 1'b0;
      wb_if.RegWrite_in_WB      = 1'b0;
      wb_if.MemtoReg_in_WB      = 1'b0;
      wb_if.size_in_WB          = 2'b00;
      wb_if.ALUResult_in_WB     = 32'd0;
      wb_if.WriteRegister_in_WB = 5'd0;
      wb_if.ReadData_in_WB      = 32'd0;
      wb_if.MemReady_in         = 1'b0;
      @(negedge Clk_in);
      test_reset();
      test_alu();
      test_byte_load();
      test_load_align();
      test_rd0();
      test_back_to_back();
      test_reset_wait_mem();
      test_wrap();
      tests_run++; if (sb.size() !== 0) begin tests_failed++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size()); end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
